// File: rtl/grp_perm_w.sv
// rtl/grp_perm_w.sv - group/ungroup bit permutation, BPC source bits per cycle.
// Forward packs Y-clear bits of X low and Y-set bits high; inverse undoes it.
module grp_perm_w #(
  parameter int WIDTH = 32,
  parameter int BPC   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_mode,
  input  logic [WIDTH-1:0]             in_x,
  input  logic [WIDTH-1:0]             in_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_p,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  output logic                         busy
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] x_q, y_q, res_q, res_n;
  logic             mode_q;
  logic [CW-1:0]    n1_q, idx_q, c0_q, c1_q;
  logic [CW-1:0]    c0_n, c1_n, src, hi;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  // Each bit is written exactly once per operation, so res_q needs no clear on capture.
  always_comb begin
    res_n = res_q;
    c0_n  = c0_q;
    c1_n  = c1_q;
    src   = '0;
    hi    = '0;
    for (int j = 0; j < BPC; j++) begin
      src = idx_q + CW'(j);
      hi  = CW'(WIDTH) - n1_q + c1_n;
      if (!mode_q) begin
        if (y_q[IW'(src)]) begin
          res_n[IW'(hi)] = x_q[IW'(src)];
          c1_n = c1_n + CW'(1);
        end else begin
          res_n[IW'(c0_n)] = x_q[IW'(src)];
          c0_n = c0_n + CW'(1);
        end
      end else begin
        if (y_q[IW'(src)]) begin
          res_n[IW'(src)] = x_q[IW'(hi)];
          c1_n = c1_n + CW'(1);
        end else begin
          res_n[IW'(src)] = x_q[IW'(c0_n)];
          c0_n = c0_n + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      res_q  <= '0;
      mode_q <= 1'b0;
      n1_q   <= '0;
      idx_q  <= '0;
      c0_q   <= '0;
      c1_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q    <= in_x;
            y_q    <= in_y;
            mode_q <= in_mode;
            n1_q   <= popcount(in_y);
            idx_q  <= '0;
            c0_q   <= '0;
            c1_q   <= '0;
          end
        end
        RUN: begin
          res_q <= res_n;
          c0_q  <= c0_n;
          c1_q  <= c1_n;
          idx_q <= idx_q + CW'(BPC);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx_q == CW'(WIDTH - BPC)) state_n = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_p    = res_q;
  assign out_ones = n1_q;

endmodule

// File: tb/tb_grp_perm_w.sv
// tb/tb_grp_perm_w.sv - directed vector bench for grp_perm_w at WIDTH 8 and 32.
module tb_grp_perm_w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, in_valid, in_mode, out_ready;
  logic [31:0] in_x, in_y;

  logic       iv8, ir8, ov8, b8, or8;
  logic [7:0] p8;
  logic [3:0] o8;
  logic        iv32, ir32, ov32, b32, or32;
  logic [31:0] p32;
  logic [5:0]  o32;

  logic        ir, ov, bz;
  logic [31:0] p;
  logic [5:0]  ones;

  assign iv8  = in_valid & ~sel;
  assign iv32 = in_valid & sel;
  assign or8  = out_ready & ~sel;
  assign or32 = out_ready & sel;
  assign ir   = sel ? ir32 : ir8;
  assign ov   = sel ? ov32 : ov8;
  assign bz   = sel ? b32 : b8;
  assign p    = sel ? p32 : {24'h0, p8};
  assign ones = sel ? o32 : {2'b00, o8};

  grp_perm_w #(.WIDTH(8), .BPC(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_mode(in_mode),
    .in_x(in_x[7:0]), .in_y(in_y[7:0]), .out_valid(ov8), .out_ready(or8),
    .out_p(p8), .out_ones(o8), .busy(b8));

  grp_perm_w dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .out_valid(ov32), .out_ready(or32),
    .out_p(p32), .out_ones(o32), .busy(b32));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        w32;
    logic        mode;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp_p;
    logic [5:0]  exp_ones;
  } vec_t;

  vec_t vecs[12];

  // Edge count includes the acceptance edge: out_valid is expected after edge N+1.
  task automatic run_op(input logic s, input logic m, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_p, input logic [5:0] exp_ones, input string tag);
    int k;
    int n;
    n = s ? 4 : 1;
    @(negedge clk);
    sel = s; in_mode = m; in_x = x; in_y = y; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, " in_ready"}, 64'(ir), 64'd1);
    @(posedge clk);
    k = 1;
    @(negedge clk);
    in_x = ~x; in_y = ~y; in_mode = ~m;
    while (!ov && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 64'(k), 64'(n + 1));
    chk({tag, " out_p"}, 64'(p), 64'(exp_p));
    chk({tag, " out_ones"}, 64'(ones), 64'(exp_ones));
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " idle after release"}, 64'({ir, ov, bz}), 64'(3'b100));
  endtask

  initial begin
    int k;
    vecs[0]  = '{1'b0, 1'b0, 32'hB2,       32'hCA,       32'h9C,       6'd4};
    vecs[1]  = '{1'b0, 1'b1, 32'h9C,       32'hCA,       32'hB2,       6'd4};
    vecs[2]  = '{1'b1, 1'b0, 32'h1234ABCD, 32'h0000FFFF, 32'hABCD1234, 6'd16};
    vecs[3]  = '{1'b1, 1'b1, 32'hABCD1234, 32'h0000FFFF, 32'h1234ABCD, 6'd16};
    vecs[4]  = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 6'd0};
    vecs[5]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 6'd0};
    vecs[6]  = '{1'b1, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 6'd32};
    vecs[7]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 6'd32};
    vecs[8]  = '{1'b0, 1'b0, 32'h0F,       32'h55,       32'h33,       6'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'hFFFF0000, 32'hAAAAAAAA, 32'hFF00FF00, 6'd16};
    vecs[10] = '{1'b0, 1'b0, 32'h80,       32'h01,       32'h40,       6'd1};
    vecs[11] = '{1'b0, 1'b1, 32'h40,       32'h01,       32'h80,       6'd1};

    rst = 1'b0; sel = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0;
    #2;
    chk("reset state w32", 64'({ir, ov, bz, p, ones}), 64'({3'b100, 32'h0, 6'd0}));
    sel = 1'b0;
    #1;
    chk("reset state w8", 64'({ir, ov, bz, p, ones}), 64'({3'b100, 32'h0, 6'd0}));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("in_ready after release", 64'(ir), 64'd1);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].w32, vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].exp_p,
             vecs[i].exp_ones, $sformatf("vec%0d", i));

    // Hold DONE with out_ready low while in_valid/in_x churn.
    @(negedge clk);
    sel = 1'b1; in_mode = 1'b0; in_x = 32'h1234ABCD; in_y = 32'h0000FFFF; in_valid = 1'b1;
    @(posedge clk);
    k = 1;
    @(negedge clk);
    while (!ov && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk("hold latency", 64'(k), 64'd5);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_x = $urandom;
      in_y = $urandom;
      chk($sformatf("hold cycle %0d", i), 64'({ov, ir, p, ones}), 64'({2'b10, 32'hABCD1234, 6'd16}));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold release idle", 64'({ir, ov, bz}), 64'(3'b100));
    @(posedge clk);
    @(negedge clk);
    chk("no second capture", 64'({ir, ov, bz}), 64'(3'b100));

    // Reset in the 2nd RUN cycle aborts the operation.
    @(negedge clk);
    sel = 1'b1; in_mode = 1'b0; in_x = 32'h1234ABCD; in_y = 32'h0000FFFF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid-run reset outputs", 64'({ir, ov, bz, p, ones}), 64'({3'b100, 32'h0, 6'd0}));
    k = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ov) k++;
    end
    chk("no out_valid during reset", 64'(k), 64'd0);
    rst = 1'b1;
    #1;
    chk("in_ready after mid-run reset", 64'(ir), 64'd1);
    run_op(1'b1, 1'b0, 32'h1234ABCD, 32'h0000FFFF, 32'hABCD1234, 6'd16, "post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
